// File: rtl/capture_ctrl_if.sv
// Camera capture controller bus: request/abort controls, camera timing
// inputs, the pixel strobe, and the gated frame-buffer write plus status.
interface capture_ctrl_if #(
    parameter int AW = 15
);
    logic          start;
    logic          stop;
    logic          mode_cont;
    logic          vsync;
    logic          href;
    logic          cam_px_wr;
    logic          mem_wr;
    logic          busy;
    logic          done;
    logic          frame_err;
    logic [7:0]    frame_cnt;
    logic [AW-1:0] pix_cnt;

    // Side that drives requests and camera timing (host / camera model)
    modport master (
        output start, stop, mode_cont, vsync, href, cam_px_wr,
        input  mem_wr, busy, done, frame_err, frame_cnt, pix_cnt
    );

    // The capture controller itself
    modport slave (
        input  start, stop, mode_cont, vsync, href, cam_px_wr,
        output mem_wr, busy, done, frame_err, frame_cnt, pix_cnt
    );
endinterface

// File: rtl/capture_ctrl.sv
// Frame capture controller: arms on start, opens a frame on the falling edge
// of vsync, gates pixel writes into the frame buffer, counts pixels and lines,
// and closes the frame on the next rising edge of vsync with an error status.
module capture_ctrl #(
    parameter int AW     = 15,
    parameter int NPIX   = 19200,
    parameter int NLINES = 120
) (
    input  logic            pclk,
    input  logic            rst,
    capture_ctrl_if.slave   bus
);
    // Line counter is one value wider than NLINES can need, so that a frame
    // with too many lines saturates above NLINES and is still flagged.
    localparam int             LW       = $clog2(NLINES + 2);
    localparam logic [AW-1:0]  NPIX_W   = AW'(NPIX);
    localparam logic [LW-1:0]  NLINES_W = LW'(NLINES);
    localparam logic [LW-1:0]  LINE_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, CAPT, DONE} state_t;

    state_t        r_state;
    logic          r_vsyncD;
    logic          r_hrefD;
    logic          r_errOvf;
    logic          r_stopPend;
    logic          r_busy;
    logic          r_done;
    logic          r_frameErr;
    logic [7:0]    r_frameCnt;
    logic [AW-1:0] r_pixCnt;
    logic [LW-1:0] r_lineCnt;

    logic          w_vsFall;
    logic          w_vsRise;
    logic          w_hrefFall;
    logic          w_pixRoom;
    logic          w_memWr;
    logic          w_errOvfNext;
    logic [AW-1:0] w_pixNext;
    logic [LW-1:0] w_lineNext;

    assign w_vsFall   = r_vsyncD & ~bus.vsync;
    assign w_vsRise   = ~r_vsyncD & bus.vsync;
    assign w_hrefFall = r_hrefD & ~bus.href;

    // The write gate is combinational so the strobe reaches the buffer in the
    // same cycle as the pixel data; a full frame blocks further writes.
    assign w_pixRoom    = (r_pixCnt < NPIX_W);
    assign w_memWr      = (r_state == CAPT) & bus.cam_px_wr & w_pixRoom;
    assign w_errOvfNext = r_errOvf | (bus.cam_px_wr & ~w_pixRoom);
    assign w_pixNext    = w_memWr ? (r_pixCnt + AW'(1)) : r_pixCnt;
    assign w_lineNext   = (w_hrefFall && (r_lineCnt != LINE_MAX))
                          ? (r_lineCnt + LW'(1)) : r_lineCnt;

    assign bus.mem_wr    = w_memWr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.frame_err = r_frameErr;
    assign bus.frame_cnt = r_frameCnt;
    assign bus.pix_cnt   = r_pixCnt;

    // Capture FSM with its counters, sync-edge history and registered status
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_vsyncD   <= 1'b0;
            r_hrefD    <= 1'b0;
            r_errOvf   <= 1'b0;
            r_stopPend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_frameErr <= 1'b0;
            r_frameCnt <= 8'd0;
            r_pixCnt   <= '0;
            r_lineCnt  <= '0;
        end else begin
            r_vsyncD <= bus.vsync;
            r_hrefD  <= bus.href;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        r_state <= ARM;
                        r_busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (bus.stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_vsFall) begin
                        r_state    <= CAPT;
                        r_pixCnt   <= '0;
                        r_lineCnt  <= '0;
                        r_errOvf   <= 1'b0;
                        r_stopPend <= 1'b0;
                    end
                end
                CAPT: begin
                    r_pixCnt   <= w_pixNext;
                    r_lineCnt  <= w_lineNext;
                    r_errOvf   <= w_errOvfNext;
                    r_stopPend <= r_stopPend | bus.stop;
                    if (w_vsRise) begin
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_frameErr <= w_errOvfNext
                                      | (w_pixNext != NPIX_W)
                                      | (w_lineNext != NLINES_W);
                        r_frameCnt <= r_frameCnt + 8'd1;
                    end
                end
                DONE: begin
                    if (bus.mode_cont && !r_stopPend && !bus.stop) begin
                        r_state <= ARM;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl with a 4-pixel, 2-line frame.
// Each table row gives the inputs driven before a rising edge and the outputs
// expected just after those inputs settle (state from the previous edges).
module tb_capture_ctrl;
    localparam int AW     = 15;
    localparam int NPIX   = 4;
    localparam int NLINES = 2;

    typedef struct {
        logic          st, sp, mc, vs, hr, px;
        logic          mw, bz, dn, fe;
        logic [7:0]    fc;
        logic [AW-1:0] pc;
    } vec_t;

    logic pclk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    capture_ctrl_if #(.AW(AW)) bus ();

    capture_ctrl #(.AW(AW), .NPIX(NPIX), .NLINES(NLINES)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    // Free-running pixel clock
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic mw, input logic bz,
                               input logic dn, input logic fe, input int fc, input int pc);
        cmp({tag, ".mem_wr"},    int'(bus.mem_wr),    int'(mw));
        cmp({tag, ".busy"},      int'(bus.busy),      int'(bz));
        cmp({tag, ".done"},      int'(bus.done),      int'(dn));
        cmp({tag, ".frame_err"}, int'(bus.frame_err), int'(fe));
        cmp({tag, ".frame_cnt"}, int'(bus.frame_cnt), fc);
        cmp({tag, ".pix_cnt"},   int'(bus.pix_cnt),   pc);
    endtask

    task automatic drive(input logic st, input logic sp, input logic mc,
                         input logic vs, input logic hr, input logic px);
        bus.start     = st;
        bus.stop      = sp;
        bus.mode_cont = mc;
        bus.vsync     = vs;
        bus.href      = hr;
        bus.cam_px_wr = px;
    endtask

    task automatic applyStimulus(input int idx);
        @(negedge pclk);
        drive(vecs[idx].st, vecs[idx].sp, vecs[idx].mc,
              vecs[idx].vs, vecs[idx].hr, vecs[idx].px);
        #1;
        checkOutput($sformatf("row%0d", idx), vecs[idx].mw, vecs[idx].bz,
                    vecs[idx].dn, vecs[idx].fe, int'(vecs[idx].fc), int'(vecs[idx].pc));
    endtask

    task automatic addVec(input logic st, input logic sp, input logic mc,
                          input logic vs, input logic hr, input logic px,
                          input logic mw, input logic bz, input logic dn,
                          input logic fe, input int fc, input int pc);
        vec_t v;
        v.st = st; v.sp = sp; v.mc = mc; v.vs = vs; v.hr = hr; v.px = px;
        v.mw = mw; v.bz = bz; v.dn = dn; v.fe = fe;
        v.fc = 8'(fc);
        v.pc = AW'(pc);
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //     st sp mc vs hr px | mw bz dn fe fc pc
        // Single shot: 2 lines of 2 pixels, clean frame
        addVec(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0, 1,   0, 1, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 2);
        addVec(0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 0, 2);
        addVec(0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 0, 3);
        addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 4);
        addVec(0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0, 4);
        addVec(0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 1, 4);
        addVec(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 4);
        // Overflow: fifth pixel is blocked and flags the frame
        addVec(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 4);
        addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 4);
        addVec(0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 1, 1);
        addVec(0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 1, 2);
        addVec(0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 1, 3);
        addVec(0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 1, 4);
        addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 4);
        addVec(0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 1, 4);
        addVec(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 2, 4);
        addVec(0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 2, 4);
        // Continuous: short frame of 3 pixels, then a full frame of 4
        addVec(1, 0, 1, 1, 0, 0,   0, 0, 0, 1, 2, 4);
        addVec(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 2, 4);
        addVec(0, 0, 1, 0, 1, 1,   1, 1, 0, 1, 2, 0);
        addVec(0, 0, 1, 0, 1, 1,   1, 1, 0, 1, 2, 1);
        addVec(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 2, 2);
        addVec(0, 0, 1, 0, 1, 1,   1, 1, 0, 1, 2, 2);
        addVec(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 2, 3);
        addVec(0, 0, 1, 1, 0, 0,   0, 1, 0, 1, 2, 3);
        addVec(0, 0, 1, 1, 0, 0,   0, 1, 1, 1, 3, 3);
        addVec(0, 0, 1, 1, 0, 1,   0, 1, 0, 1, 3, 3);
        addVec(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 3, 3);
        addVec(0, 0, 1, 0, 1, 1,   1, 1, 0, 1, 3, 0);
        addVec(0, 0, 1, 0, 1, 1,   1, 1, 0, 1, 3, 1);
        addVec(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 3, 2);
        addVec(0, 0, 1, 0, 1, 1,   1, 1, 0, 1, 3, 2);
        addVec(0, 0, 1, 0, 1, 1,   1, 1, 0, 1, 3, 3);
        addVec(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 3, 4);
        addVec(0, 0, 1, 1, 0, 0,   0, 1, 0, 1, 3, 4);
        addVec(0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 4, 4);
        addVec(0, 0, 1, 1, 0, 0,   0, 1, 0, 0, 4, 4);
        // Stop while armed, then start+stop together in IDLE
        addVec(0, 1, 1, 1, 0, 0,   0, 1, 0, 0, 4, 4);
        addVec(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 4, 4);
        addVec(1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 4, 4);
        addVec(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 4, 4);
        // Stop during capture in continuous mode: frame closes, then IDLE
        addVec(1, 0, 1, 1, 0, 0,   0, 0, 0, 0, 4, 4);
        addVec(0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 4, 4);
        addVec(0, 0, 1, 0, 1, 1,   1, 1, 0, 0, 4, 0);
        addVec(0, 1, 1, 0, 0, 0,   0, 1, 0, 0, 4, 1);
        addVec(0, 0, 1, 1, 0, 0,   0, 1, 0, 0, 4, 1);
        addVec(0, 0, 1, 1, 0, 0,   0, 1, 1, 1, 5, 1);
        addVec(0, 0, 1, 1, 0, 0,   0, 0, 0, 1, 5, 1);

        // Reset state
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("reset", 0, 0, 0, 0, 0, 0);
        @(negedge pclk);
        @(negedge pclk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i);
        end

        // Reset in the middle of a frame after two pixels
        @(negedge pclk);
        drive(1, 0, 0, 1, 0, 0);
        @(negedge pclk);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge pclk);
        drive(0, 0, 0, 0, 1, 1);
        #1;
        checkOutput("midrst.capt", 1, 1, 0, 1, 5, 0);
        @(negedge pclk);
        #1;
        checkOutput("midrst.px1", 1, 1, 0, 1, 5, 1);
        @(negedge pclk);
        rst = 1'b0;
        #1;
        checkOutput("midrst.assert", 0, 0, 0, 0, 0, 0);
        @(negedge pclk);
        rst = 1'b1;
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            #1;
            checkOutput($sformatf("midrst.after%0d", i), 0, 0, 0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 15; address width of the frame buffer.
REQ-002 The block SHALL have parameter NPIX, default 19200; pixels per frame (160x120).
REQ-003 The block SHALL have parameter NLINES, default 120; href lines per frame.
REQ-004 The block SHALL have port pclk, input, 1 bit; the only clock, with all flops on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit; reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit; capture request, sampled on pclk.
REQ-007 The block SHALL have port stop, input, 1 bit; abort or stop-after-frame request.
REQ-008 The block SHALL have port mode_cont, input, 1 bit; 1 selects continuous capture, 0 selects single shot.
REQ-009 The block SHALL have port vsync, input, 1 bit; camera vertical sync, high during blanking.
REQ-010 The block SHALL have port href, input, 1 bit; camera line-valid signal.
REQ-011 The block SHALL have port cam_px_wr, input, 1 bit; pixel-write strobe from the capture datapath.
REQ-012 The block SHALL have port mem_wr, output, 1 bit; gated write enable to the frame buffer.
REQ-013 The block SHALL have port busy, output, 1 bit; high in any state other than IDLE.
REQ-014 The block SHALL have port done, output, 1 bit; one-cycle pulse at frame end.
REQ-015 The block SHALL have port frame_err, output, 1 bit; status of the last completed frame (pixel or line count mismatch).
REQ-016 The block SHALL have port frame_cnt, output, 8 bits; count of completed frames, wrapping.
REQ-017 The block SHALL have port pix_cnt, output, AW bits; pixels accepted in the current frame.

Function
REQ-018 The block SHALL implement four states: IDLE, ARM, CAPT and DONE.
REQ-019 The block SHALL register vsync and href into vsync_d and href_d every cycle, with both reset to 0.
REQ-020 Edge detection SHALL be defined as follows: vs_fall = vsync_d & ~vsync; vs_rise = ~vsync_d & vsync; href_fall = href_d & ~href.
REQ-021 In IDLE, start=1 with stop=0 SHALL move the block to ARM on the next cycle, and start=1 with stop=1 SHALL keep it in IDLE (stop wins).
REQ-022 In ARM, stop=1 SHALL move the block to IDLE; otherwise vs_fall SHALL move it to CAPT and clear pix_cnt, the line counter, err_ovf and stop_pend.
REQ-023 In ARM, a vs_rise SHALL be ignored.
REQ-024 In CAPT, mem_wr SHALL equal cam_px_wr & (pix_cnt < NPIX), combinationally in the same cycle.
REQ-025 mem_wr SHALL be 0 in every state other than CAPT.
REQ-026 In CAPT, pix_cnt SHALL increment by 1 on each cycle where mem_wr=1.
REQ-027 In CAPT, cam_px_wr=1 with pix_cnt=NPIX SHALL set err_ovf, suppress the write and leave pix_cnt unchanged (saturate).
REQ-028 In CAPT, the internal line counter SHALL increment on each href_fall and SHALL saturate at its maximum value.
REQ-029 In CAPT, stop=1 SHALL set stop_pend and the current frame SHALL still complete.
REQ-030 In CAPT, vs_rise SHALL move the block to DONE.
REQ-031 On the CAPT-to-DONE transition, frame_err SHALL load err_ovf | (pix_cnt != NPIX) | (lines != NLINES), using the counts including any write or href_fall in that same cycle.
REQ-032 On the CAPT-to-DONE transition, frame_cnt SHALL increment modulo 256.
REQ-033 In DONE, done SHALL be 1 for exactly one cycle.
REQ-034 From DONE, the next state SHALL be ARM if mode_cont=1 and stop_pend=0 and stop=0; otherwise it SHALL be IDLE.
REQ-035 start SHALL be ignored in any state other than IDLE.
REQ-036 frame_err and frame_cnt SHALL hold their values until the next DONE or reset.
REQ-037 pix_cnt SHALL hold its value after DONE until the next entry into CAPT.
REQ-038 Every state and output transition SHALL take effect one pclk after the qualifying input, except mem_wr, which is combinational.

Reset
REQ-039 While rst=0, the block SHALL force state=IDLE, with mem_wr, busy, done, frame_err, frame_cnt, pix_cnt, the line counter, err_ovf, stop_pend, vsync_d and href_d all 0, without waiting for a clock edge.
REQ-040 Reset asserted mid-CAPT SHALL abandon the frame: no done pulse and no frame_cnt update.
REQ-041 After rst deasserts, the block SHALL remain in IDLE until start is asserted.

Verification (bench parameters NPIX=4, NLINES=2)
REQ-042 Single shot: start, then vs_fall, then 2 lines of 2 cam_px_wr each, then vs_rise -> 4 mem_wr pulses, pix_cnt=4, done pulse, frame_err=0, frame_cnt=1, state IDLE.
REQ-043 Overflow: 5 cam_px_wr within the frame -> exactly 4 mem_wr pulses, pix_cnt=4, frame_err=1 at done.
REQ-044 Short frame and continuous mode: mode_cont=1 with 3 pixels in frame 1 and 4 in frame 2 -> frame_err=1 after frame 1, then 0 after frame 2, frame_cnt=2, state ARM.
REQ-045 Stop handling: stop during ARM -> IDLE next cycle with no done; stop during CAPT with mode_cont=1 -> frame completes, done pulses, then IDLE.
REQ-046 Edge cases: start and stop together in IDLE -> stays IDLE; cam_px_wr while in IDLE or ARM -> mem_wr=0.
REQ-047 Reset mid-CAPT after 2 pixels -> all outputs 0 immediately, frame_cnt=0, and no done pulse.
